// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencer driving lives, state and start/respawn/clear pulses.
// Define PAUSE_EN to build the PAUSE state and pause button handling.
module game_flow_ctrl #(
    parameter int LIVES_INIT     = 3,
    parameter int RESPAWN_FRAMES = 60,
    parameter int OVER_FRAMES    = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enter,
    input  logic       pause_btn,
    input  logic       hit,
    input  logic       frame_tick,
    output logic       start,
    output logic       respawn,
    output logic       clear,
    output logic       game_active,
    output logic       freeze,
    output logic       game_over,
    output logic [2:0] lives,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_RESPAWN = 3'd2,
        ST_OVER    = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [7:0] timer_q, timer_d;
    logic       start_q, start_d;
    logic       respawn_q, respawn_d;
    logic       clear_q, clear_d;
    logic       enter_q;
    logic       enter_rise;
    logic       pause_rise;

    assign enter_rise = enter & ~enter_q;

`ifdef PAUSE_EN
    logic pause_q;

    assign pause_rise = pause_btn & ~pause_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pause_q <= 1'b1;
        end else begin
            pause_q <= pause_btn;
        end
    end
`else
    logic unused_pause_btn;

    assign unused_pause_btn = pause_btn;
    assign pause_rise       = 1'b0;
`endif

    // Edge-detect registers reset high so a button held through reset never fires.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lives_q   <= 3'd0;
            timer_q   <= 8'd0;
            start_q   <= 1'b0;
            respawn_q <= 1'b0;
            clear_q   <= 1'b0;
            enter_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            timer_q   <= timer_d;
            start_q   <= start_d;
            respawn_q <= respawn_d;
            clear_q   <= clear_d;
            enter_q   <= enter;
        end
    end

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        timer_d   = timer_q;
        start_d   = 1'b0;
        respawn_d = 1'b0;
        clear_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enter_rise) begin
                    state_d = ST_PLAY;
                    lives_d = 3'(LIVES_INIT);
                    start_d = 1'b1;
                    clear_d = 1'b1;
                end
            end
            ST_PLAY: begin
                // A hit wins over a simultaneous pause press, which is simply dropped.
                if (hit) begin
                    clear_d = 1'b1;
                    if (lives_q > 3'd1) begin
                        state_d = ST_RESPAWN;
                        lives_d = lives_q - 3'd1;
                        timer_d = 8'(RESPAWN_FRAMES);
                    end else begin
                        state_d = ST_OVER;
                        lives_d = 3'd0;
                        timer_d = 8'(OVER_FRAMES);
                    end
                end else if (pause_rise) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_RESPAWN: begin
                if (frame_tick) begin
                    if (timer_q <= 8'd1) begin
                        state_d   = ST_PLAY;
                        timer_d   = 8'd0;
                        respawn_d = 1'b1;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            ST_OVER: begin
                // Early enter presses are discarded, not remembered.
                if (enter_rise && (timer_q == 8'd0)) begin
                    state_d = ST_IDLE;
                end else if (frame_tick && (timer_q != 8'd0)) begin
                    timer_d = timer_q - 8'd1;
                end
            end
`ifdef PAUSE_EN
            ST_PAUSE: begin
                if (pause_rise) begin
                    state_d = ST_PLAY;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign start       = start_q;
    assign respawn     = respawn_q;
    assign clear       = clear_q;
    assign lives       = lives_q;
    assign state       = state_q;
    assign game_active = (state_q == ST_PLAY);
    assign game_over   = (state_q == ST_OVER);
`ifdef PAUSE_EN
    assign freeze      = (state_q == ST_RESPAWN) || (state_q == ST_PAUSE);
`else
    assign freeze      = (state_q == ST_RESPAWN);
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed scenarios plus randomized run against a behavioural game model.
module tb_game_flow_ctrl;

`ifdef PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       enter;
    logic       pause_btn;
    logic       hit;
    logic       frame_tick;
    logic       start;
    logic       respawn;
    logic       clear;
    logic       game_active;
    logic       freeze;
    logic       game_over;
    logic [2:0] lives;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Behavioural model: game phase number, lives, frames left, pulses, last button levels.
    int m_phase;
    int m_lives;
    int m_frames;
    bit m_start, m_respawn, m_clear;
    bit m_enter_last, m_pause_last;

    game_flow_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .enter       (enter),
        .pause_btn   (pause_btn),
        .hit         (hit),
        .frame_tick  (frame_tick),
        .start       (start),
        .respawn     (respawn),
        .clear       (clear),
        .game_active (game_active),
        .freeze      (freeze),
        .game_over   (game_over),
        .lives       (lives),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_step(input bit r, input bit e, input bit p, input bit h, input bit f);
        bit pressed_enter;
        bit pressed_pause;
        m_start   = 0;
        m_respawn = 0;
        m_clear   = 0;
        if (r) begin
            m_phase      = 0;
            m_lives      = 0;
            m_frames     = 0;
            m_enter_last = 1;
            m_pause_last = 1;
            return;
        end
        pressed_enter = e && !m_enter_last;
        pressed_pause = PAUSE_ON && p && !m_pause_last;
        m_enter_last  = e;
        m_pause_last  = p;
        if (m_phase == 0) begin
            if (pressed_enter) begin
                m_phase = 1; m_lives = 3; m_start = 1; m_clear = 1;
            end
        end else if (m_phase == 1) begin
            if (h) begin
                m_clear = 1;
                if (m_lives > 1) begin
                    m_lives = m_lives - 1; m_frames = 60; m_phase = 2;
                end else begin
                    m_lives = 0; m_frames = 120; m_phase = 3;
                end
            end else if (pressed_pause) begin
                m_phase = 4;
            end
        end else if (m_phase == 2) begin
            if (f) begin
                m_frames = m_frames - 1;
                if (m_frames == 0) begin
                    m_phase = 1; m_respawn = 1;
                end
            end
        end else if (m_phase == 3) begin
            if (pressed_enter && m_frames == 0) m_phase = 0;
            else if (f && m_frames > 0) m_frames = m_frames - 1;
        end else if (m_phase == 4) begin
            if (pressed_pause) m_phase = 1;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit p, input bit h, input bit f);
        reset      = r;
        enter      = e;
        pause_btn  = p;
        hit        = h;
        frame_tick = f;
        @(posedge clock);
        model_step(r, e, p, h, f);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        checks++; if (lives !== 3'd0) begin errors++; $display("[TB] FAIL reset_lives: got %0d expected 0", lives); end
        checks++; if (start !== 1'b0 || clear !== 1'b0 || respawn !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got %b%b%b expected 000", start, clear, respawn); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            checks++; if (start !== 1'b0 || state !== 3'd0) begin errors++; $display("[TB] FAIL held_enter: got start=%b state=%0d expected start=0 state=0", start, state); end
        end
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        checks++; if (start !== 1'b1) begin errors++; $display("[TB] FAIL start_pulse: got %b expected 1", start); end
        checks++; if (clear !== 1'b1) begin errors++; $display("[TB] FAIL start_clear: got %b expected 1", clear); end
        checks++; if (state !== 3'd1 || game_active !== 1'b1) begin errors++; $display("[TB] FAIL start_state: got %0d/%b expected 1/1", state, game_active); end
        checks++; if (lives !== 3'd3) begin errors++; $display("[TB] FAIL start_lives: got %0d expected 3", lives); end
        step(0, 1, 0, 0, 0);
        checks++; if (start !== 1'b0 || clear !== 1'b0) begin errors++; $display("[TB] FAIL start_width: got start=%b clear=%b expected 0 0", start, clear); end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_respawn();
        step(0, 0, 0, 1, 0);
        checks++; if (state !== 3'd2 || lives !== 3'd2) begin errors++; $display("[TB] FAIL hit_respawn: got state=%0d lives=%0d expected 2 2", state, lives); end
        checks++; if (clear !== 1'b1 || freeze !== 1'b1 || game_active !== 1'b0) begin errors++; $display("[TB] FAIL hit_flags: got clear=%b freeze=%b active=%b expected 1 1 0", clear, freeze, game_active); end
        for (int i = 1; i <= 60; i++) begin
            step(0, 0, 0, 0, 1);
            if (i < 60) begin
                checks++; if (respawn !== 1'b0 || state !== 3'd2) begin errors++; $display("[TB] FAIL respawn_early tick %0d: got respawn=%b state=%0d expected 0 2", i, respawn, state); end
            end else begin
                checks++; if (respawn !== 1'b1 || state !== 3'd1) begin errors++; $display("[TB] FAIL respawn_pulse: got respawn=%b state=%0d expected 1 1", respawn, state); end
            end
        end
        step(0, 0, 0, 0, 0);
        checks++; if (respawn !== 1'b0) begin errors++; $display("[TB] FAIL respawn_width: got %b expected 0", respawn); end
    endtask

    task automatic test_game_over();
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 60; i++) step(0, 0, 0, 0, 1);
        checks++; if (state !== 3'd1 || lives !== 3'd1) begin errors++; $display("[TB] FAIL last_life: got state=%0d lives=%0d expected 1 1", state, lives); end
        step(0, 0, 0, 1, 0);
        checks++; if (state !== 3'd3 || lives !== 3'd0 || game_over !== 1'b1) begin errors++; $display("[TB] FAIL over_entry: got state=%0d lives=%0d go=%b expected 3 0 1", state, lives, game_over); end
        checks++; if (clear !== 1'b1) begin errors++; $display("[TB] FAIL over_clear: got %b expected 1", clear); end
        for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        checks++; if (state !== 3'd3) begin errors++; $display("[TB] FAIL enter_at_50: got %0d expected 3", state); end
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 69; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        checks++; if (state !== 3'd3) begin errors++; $display("[TB] FAIL enter_at_119: got %0d expected 3", state); end
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        checks++; if (state !== 3'd0 || game_over !== 1'b0 || lives !== 3'd0) begin errors++; $display("[TB] FAIL enter_at_120: got state=%0d go=%b lives=%0d expected 0 0 0", state, game_over, lives); end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_hit_pause_same_cycle();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        checks++; if (state !== 3'd2 || lives !== 3'd2) begin errors++; $display("[TB] FAIL hit_over_pause: got state=%0d lives=%0d expected 2 2", state, lives); end
        for (int i = 0; i < 60; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL pause_dropped: got %0d expected 1", state); end
    endtask

    task automatic test_pause();
        step(0, 0, 1, 0, 0);
`ifdef PAUSE_EN
        checks++; if (state !== 3'd4 || freeze !== 1'b1 || game_active !== 1'b0) begin errors++; $display("[TB] FAIL pause_enter: got state=%0d freeze=%b expected 4 1", state, freeze); end
        step(0, 0, 0, 1, 0);
        checks++; if (state !== 3'd4 || lives !== 3'd2) begin errors++; $display("[TB] FAIL pause_hit: got state=%0d lives=%0d expected 4 2", state, lives); end
        step(0, 1, 0, 0, 1);
        checks++; if (state !== 3'd4) begin errors++; $display("[TB] FAIL pause_enter_ignored: got %0d expected 4", state); end
        step(0, 0, 1, 0, 0);
        checks++; if (state !== 3'd1 || freeze !== 1'b0) begin errors++; $display("[TB] FAIL pause_exit: got state=%0d freeze=%b expected 1 0", state, freeze); end
`else
        checks++; if (state !== 3'd1 || freeze !== 1'b0) begin errors++; $display("[TB] FAIL pause_disabled: got state=%0d freeze=%b expected 1 0", state, freeze); end
`endif
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_respawn();
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        checks++; if (state !== 3'd0 || lives !== 3'd0 || respawn !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset: got state=%0d lives=%0d respawn=%b expected 0 0 0", state, lives, respawn); end
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 0, 1);
            checks++; if (respawn !== 1'b0 || state !== 3'd0) begin errors++; $display("[TB] FAIL post_reset: got respawn=%b state=%0d expected 0 0", respawn, state); end
        end
    endtask

    task automatic test_random();
        bit e, p, h, f, r;
        int exp_fz;
        e = 0; p = 0;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) e = ~e;
            if ($urandom_range(0, 9) == 0) p = ~p;
            h = ($urandom_range(0, 15) == 0);
            f = ($urandom_range(0, 1) == 0);
            r = ($urandom_range(0, 499) == 0);
            step(r, e, p, h, f);
            exp_fz = (m_phase == 2 || (PAUSE_ON && m_phase == 4)) ? 1 : 0;
            checks++;
            if (state !== 3'(m_phase) || lives !== 3'(m_lives) || start !== m_start || respawn !== m_respawn ||
                clear !== m_clear || game_active !== (m_phase == 1) || game_over !== (m_phase == 3) || freeze !== exp_fz[0]) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got st=%0d lv=%0d s/r/c=%b%b%b fz=%b expected st=%0d lv=%0d s/r/c=%b%b%b fz=%0d",
                         i, state, lives, start, respawn, clear, freeze, m_phase, m_lives, m_start, m_respawn, m_clear, exp_fz);
            end
        end
    endtask

    initial begin
        reset = 1; enter = 0; pause_btn = 0; hit = 0; frame_tick = 0;
        m_phase = 0; m_lives = 0; m_frames = 0;
        m_start = 0; m_respawn = 0; m_clear = 0;
        m_enter_last = 1; m_pause_last = 1;
        test_reset();
        test_respawn();
        test_game_over();
        test_hit_pause_same_cycle();
        test_pause();
        test_reset_mid_respawn();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
